// File: rtl/nova_io_pkg.sv
// Shared definitions for the Nova I/O bus arbiter: sequencer states, grant
// owners and the fields of an 8-bit I/O address.
package nova_io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STB  = 2'd1,
    ST_CAPT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DCH = 1'b1
  } owner_t;

  // Device code of the CPU itself (IORST lives at register 3 of this device)
  localparam logic [0:5] DEV_CPU = 6'o77;

  // Address is MSB-first: [0:5] device code, [6:7] register select
  localparam int DEV_F_LO = 0;
  localparam int DEV_F_HI = 5;
  localparam int REG_F_LO = 6;
  localparam int REG_F_HI = 7;

  function automatic logic [0:5] adr_dev(input logic [0:7] adr);
    return adr[DEV_F_LO:DEV_F_HI];
  endfunction

  function automatic logic [0:1] adr_reg(input logic [0:7] adr);
    return adr[REG_F_LO:REG_F_HI];
  endfunction

endpackage

// File: rtl/nova_io_bus_arb.sv
// Arbitrates the shared Nova I/O bus between the CPU I/O unit and the data
// channel, running each grant as a fixed IDLE/STB/CAPT/DONE sequence.
module nova_io_bus_arb
  import nova_io_pkg::*;
#(
  parameter logic [3:0] DCH_MAX = 4'd4
) (
  input  logic        pclk,
  input  logic        prst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [0:7]  cpu_adr,
  input  logic [0:15] cpu_din,
  output logic        cpu_ack,
  output logic [0:15] cpu_dout,
  input  logic        dch_req,
  input  logic        dch_we,
  input  logic [0:7]  dch_adr,
  input  logic [0:15] dch_din,
  output logic        dch_ack,
  output logic [0:15] dch_dout,
  output logic        bs_stb,
  output logic        bs_we,
  output logic [0:7]  bs_adr,
  output logic [0:15] bs_din,
  input  logic [0:15] bs_dout,
  input  logic        bs_rst
);

  state_t      r_state;
  owner_t      r_owner;
  logic [3:0]  r_cnt;
  logic        r_stb;
  logic        r_we;
  logic [0:7]  r_adr;
  logic [0:15] r_din;
  logic        r_cpu_ack;
  logic        r_dch_ack;
  logic [0:15] r_cpu_dout;
  logic [0:15] r_dch_dout;

  logic        w_cpu_due;
  logic        w_dch_win;
  logic        w_cpu_win;
  logic        w_grant;
  logic [3:0]  w_cnt_inc;

  // The CPU pre-empts DCH only once DCH has used up its run of grants
  assign w_cpu_due = cpu_req && (r_cnt == DCH_MAX) && (DCH_MAX != 4'd0);
  assign w_dch_win = dch_req && !w_cpu_due;
  assign w_cpu_win = !w_dch_win && cpu_req;
  assign w_grant   = !bs_rst && (w_dch_win || w_cpu_win);
  assign w_cnt_inc = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;

  always_ff @(posedge pclk) begin
    if (prst) begin
      r_state    <= ST_IDLE;
      r_owner    <= OWN_CPU;
      r_cnt      <= 4'd0;
      r_stb      <= 1'b0;
      r_we       <= 1'b0;
      r_adr      <= '0;
      r_din      <= '0;
      r_cpu_ack  <= 1'b0;
      r_dch_ack  <= 1'b0;
      r_cpu_dout <= '0;
      r_dch_dout <= '0;
    end else begin
      r_stb     <= 1'b0;
      r_cpu_ack <= 1'b0;
      r_dch_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_stb   <= 1'b1;
            r_state <= ST_STB;
            if (w_dch_win) begin
              r_owner <= OWN_DCH;
              r_we    <= dch_we;
              r_adr   <= dch_adr;
              r_din   <= dch_din;
              r_cnt   <= cpu_req ? w_cnt_inc : 4'd0;
            end else begin
              r_owner <= OWN_CPU;
              r_we    <= cpu_we;
              r_adr   <= cpu_adr;
              r_din   <= cpu_din;
              r_cnt   <= 4'd0;
            end
          end
        end
        ST_STB: r_state <= ST_CAPT;
        ST_CAPT: begin
          // Writes return zero; reads return whatever the bus holds, responder or not
          if (r_owner == OWN_DCH) begin
            r_dch_dout <= r_we ? 16'h0000 : bs_dout;
            r_dch_ack  <= 1'b1;
          end else begin
            r_cpu_dout <= r_we ? 16'h0000 : bs_dout;
            r_cpu_ack  <= 1'b1;
          end
          r_state <= ST_DONE;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bs_stb   = r_stb;
  assign bs_we    = r_we;
  assign bs_adr   = r_adr;
  assign bs_din   = r_din;
  assign cpu_ack  = r_cpu_ack;
  assign dch_ack  = r_dch_ack;
  assign cpu_dout = r_cpu_dout;
  assign dch_dout = r_dch_dout;

endmodule
